// File: rtl/mem_port_arbiter.sv
// Two-port round-robin arbiter in front of the single-port SPM, with a bounded burst hold.
// Define ARB_FIXED_PRIO_EN for strict port-0 priority (only port 1 is ever pre-empted).
module mem_port_arbiter #(
  parameter int word_size = 8,
  parameter int addr_size = 8,
  parameter int max_burst = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req0,
  input  logic                 we0,
  input  logic [addr_size-1:0] addr0,
  input  logic [word_size-1:0] wdata0,
  output logic                 gnt0,
  output logic [word_size-1:0] rdata0,
  input  logic                 req1,
  input  logic                 we1,
  input  logic [addr_size-1:0] addr1,
  input  logic [word_size-1:0] wdata1,
  output logic                 gnt1,
  output logic [word_size-1:0] rdata1,
  output logic [addr_size-1:0] mem_addr,
  output logic [word_size-1:0] mem_din,
  output logic                 mem_write,
  input  logic [word_size-1:0] mem_dout
);

  localparam int BW = $clog2(max_burst + 1);
  localparam logic [BW-1:0] BMAX = BW'(max_burst);
`ifdef ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  state_t        state_q, state_d;
  logic          last_q, last_d;
  logic [BW-1:0] bcnt_q, bcnt_d;
  logic [BW-1:0] bcnt_inc;

  assign bcnt_inc = (bcnt_q == BMAX) ? BMAX : bcnt_q + BW'(1);

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    bcnt_d  = bcnt_q;
    case (state_q)
      IDLE: begin
        if (req0 && req1)  state_d = (FIXED || last_q) ? OWN0 : OWN1;
        else if (req0)     state_d = OWN0;
        else if (req1)     state_d = OWN1;
      end
      OWN0: begin
        if (!req0)                                        state_d = req1 ? OWN1 : IDLE;
        else if (!FIXED && req1 && (bcnt_q == BMAX))      state_d = OWN1;
        else                                              bcnt_d  = bcnt_inc;
      end
      OWN1: begin
        if (!req1)                                        state_d = req0 ? OWN0 : IDLE;
        else if (req0 && (bcnt_q == BMAX))                state_d = OWN0;
        else                                              bcnt_d  = bcnt_inc;
      end
      default: state_d = IDLE;
    endcase
    // Any change of owner restarts the burst count and records the new owner.
    if (state_d == OWN0 && state_q != OWN0) begin
      bcnt_d = BW'(1);
      last_d = 1'b0;
    end else if (state_d == OWN1 && state_q != OWN1) begin
      bcnt_d = BW'(1);
      last_d = 1'b1;
    end else if (state_d == IDLE) begin
      bcnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      bcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      bcnt_q  <= bcnt_d;
    end
  end

  assign gnt0 = (state_q == OWN0);
  assign gnt1 = (state_q == OWN1);

  // Memory mux follows the registered owner; a reset cycle never writes.
  always_comb begin
    mem_addr  = '0;
    mem_din   = '0;
    mem_write = 1'b0;
    rdata0    = '0;
    rdata1    = '0;
    case (state_q)
      OWN0: begin
        mem_addr  = addr0;
        mem_din   = wdata0;
        mem_write = we0 & req0 & ~rst;
        rdata0    = mem_dout;
      end
      OWN1: begin
        mem_addr  = addr1;
        mem_din   = wdata1;
        mem_write = we1 & req1 & ~rst;
        rdata1    = mem_dout;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed scenarios then random traffic,
// checked against an owner/burst reference model and a shadow memory.
module tb_mem_port_arbiter;

  localparam int MAXB = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
  logic [7:0] addr0 = '0, wdata0 = '0, addr1 = '0, wdata1 = '0;
  logic       gnt0, gnt1, mem_write;
  logic [7:0] rdata0, rdata1, mem_addr, mem_din, mem_dout;

  always #5 clk = ~clk;

  mem_port_arbiter #(.word_size(8), .addr_size(8), .max_burst(MAXB)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .gnt0(gnt0), .rdata0(rdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .gnt1(gnt1), .rdata1(rdata1),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_write(mem_write), .mem_dout(mem_dout)
  );

  // SPM: asynchronous read, posedge write.
  logic [7:0] spm [256];
  initial for (int i = 0; i < 256; i++) spm[i] = 8'h00;
  always @(posedge clk) if (mem_write) spm[mem_addr] <= mem_din;
  assign mem_dout = spm[mem_addr];

  typedef struct {
    logic       g0, g1, mw;
    logic [7:0] ma, md, r0, r1;
  } exp_t;

  exp_t       sb_q[$];
  int         n_checks = 0;
  int         n_pass   = 0;

  // Reference model: who owns the memory, how long they have held it, who owned it last.
  int         owner = -1;
  int         held  = 0;
  int         last_owner = 1;
  logic [7:0] ref_mem [256];
  initial for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic step(input logic rs,
                      input logic r0, input logic w0, input logic [7:0] a0, input logic [7:0] d0,
                      input logic r1, input logic w1, input logic [7:0] a1, input logic [7:0] d1);
    exp_t       e;
    logic       r[2], w[2];
    logic [7:0] a[2], d[2];
    int         k, o;
    bit         fixed;
    @(posedge clk); #1;
    rst = rs; req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0;
    req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1;
    r[0] = r0; r[1] = r1; w[0] = w0; w[1] = w1; a[0] = a0; a[1] = a1; d[0] = d0; d[1] = d1;
`ifdef ARB_FIXED_PRIO_EN
    fixed = 1'b1;
`else
    fixed = 1'b0;
`endif
    e = '{g0: 1'b0, g1: 1'b0, mw: 1'b0, ma: 8'h00, md: 8'h00, r0: 8'h00, r1: 8'h00};
    if (owner >= 0) begin
      k = owner;
      e.g0 = (k == 0);
      e.g1 = (k == 1);
      e.ma = a[k];
      e.md = d[k];
      e.mw = r[k] && w[k] && !rs;
      if (k == 0) e.r0 = ref_mem[a[k]];
      else        e.r1 = ref_mem[a[k]];
    end
    sb_q.push_back(e);
    if (e.mw) ref_mem[e.ma] = e.md;
    // Ownership for the next cycle.
    if (rs) begin
      owner = -1; held = 0; last_owner = 1;
    end else if (owner < 0) begin
      if (r[0] && r[1]) k = fixed ? 0 : 1 - last_owner;
      else if (r[0])    k = 0;
      else if (r[1])    k = 1;
      else              k = -1;
      if (k >= 0) begin owner = k; held = 1; last_owner = k; end
    end else begin
      k = owner; o = 1 - k;
      if (!r[k]) begin
        if (r[o]) begin owner = o; held = 1; last_owner = o; end
        else begin owner = -1; held = 0; end
      end else if (r[o] && held == MAXB && (!fixed || k == 1)) begin
        owner = o; held = 1; last_owner = o;
      end else begin
        held = (held + 1 > MAXB) ? MAXB : held + 1;
      end
    end
  endtask

  // Monitor: every cycle the DUT presents grant, mux and read-data outputs.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      chk("exclusive_gnt", {15'd0, gnt0 & gnt1}, 16'd0);
      chk("write_needs_gnt", {15'd0, mem_write & ~(gnt0 | gnt1)}, 16'd0);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("gnt", {14'd0, gnt0, gnt1}, {14'd0, e.g0, e.g1});
        chk("mem_write", {15'd0, mem_write}, {15'd0, e.mw});
        chk("mem_addr", {8'd0, mem_addr}, {8'd0, e.ma});
        chk("mem_din", {8'd0, mem_din}, {8'd0, e.md});
        chk("rdata0", {8'd0, rdata0}, {8'd0, e.r0});
        chk("rdata1", {8'd0, rdata1}, {8'd0, e.r1});
      end
    end
  end

  initial begin
    logic       rr0, rr1, rrs;
    int         mism;
    // Reset, then port 0 single write of A5 to 0x10.
    step(1, 0,0,8'h00,8'h00, 0,0,8'h00,8'h00);
    step(1, 1,1,8'h10,8'hA5, 0,0,8'h00,8'h00);
    step(0, 1,1,8'h10,8'hA5, 0,0,8'h00,8'h00);
    step(0, 1,1,8'h10,8'hA5, 0,0,8'h00,8'h00);
    step(0, 0,1,8'h10,8'h5A, 0,0,8'h00,8'h00);
    step(0, 0,0,8'h00,8'h00, 0,0,8'h00,8'h00);
    chk("mem_10_written", {8'd0, spm[8'h10]}, 16'h00A5);
    // Port 1 reads it back.
    step(0, 0,0,8'h00,8'h00, 1,0,8'h10,8'h00);
    step(0, 0,0,8'h00,8'h00, 1,0,8'h10,8'h00);
    step(0, 0,0,8'h00,8'h00, 0,0,8'h10,8'h00);
    // Simultaneous requests after reset, handover, re-tie from idle.
    step(1, 0,0,8'h00,8'h00, 0,0,8'h00,8'h00);
    step(0, 1,0,8'h01,8'h00, 1,0,8'h02,8'h00);
    step(0, 1,0,8'h01,8'h00, 1,0,8'h02,8'h00);
    step(0, 0,0,8'h01,8'h00, 1,0,8'h02,8'h00);
    step(0, 0,0,8'h01,8'h00, 1,0,8'h02,8'h00);
    step(0, 0,0,8'h01,8'h00, 0,0,8'h02,8'h00);
    step(0, 0,0,8'h00,8'h00, 0,0,8'h00,8'h00);
    step(0, 1,0,8'h01,8'h00, 1,0,8'h02,8'h00);
    step(0, 1,0,8'h01,8'h00, 1,0,8'h02,8'h00);
    step(0, 0,0,8'h00,8'h00, 0,0,8'h00,8'h00);
    step(0, 0,0,8'h00,8'h00, 0,0,8'h00,8'h00);
    // Burst limit: port 0 held, port 1 joins in port 0's second grant cycle.
    step(0, 1,1,8'h20,8'h11, 0,0,8'h00,8'h00);
    step(0, 1,1,8'h21,8'h12, 0,0,8'h00,8'h00);
    for (int i = 0; i < 14; i++)
      step(0, 1,1,8'h22 + 8'(i),8'h20 + 8'(i), 1,1,8'h40 + 8'(i),8'h60 + 8'(i));
    step(0, 0,0,8'h00,8'h00, 0,0,8'h00,8'h00);
    step(0, 0,0,8'h00,8'h00, 0,0,8'h00,8'h00);
    // Reset pulse in the middle of a port 1 write burst.
    step(0, 0,0,8'h00,8'h00, 1,1,8'h50,8'h77);
    step(0, 0,0,8'h00,8'h00, 1,1,8'h51,8'h78);
    step(1, 0,0,8'h00,8'h00, 1,1,8'h52,8'h79);
    step(0, 1,0,8'h00,8'h00, 1,1,8'h53,8'h7A);
    step(0, 1,0,8'h00,8'h00, 1,1,8'h54,8'h7B);
    step(0, 0,0,8'h00,8'h00, 0,0,8'h00,8'h00);
    // Random traffic with sticky requests so bursts and pre-emption occur.
    rr0 = 1'b0; rr1 = 1'b0;
    for (int i = 0; i < 10000; i++) begin
      if ($urandom_range(3) == 0) rr0 = ~rr0;
      if ($urandom_range(3) == 0) rr1 = ~rr1;
      rrs = ($urandom_range(499) == 0);
      step(rrs, rr0, 1'($urandom), 8'($urandom_range(15)), 8'($urandom),
                rr1, 1'($urandom), 8'($urandom_range(15)), 8'($urandom));
    end
    step(0, 0,0,8'h00,8'h00, 0,0,8'h00,8'h00);
    @(negedge clk); @(negedge clk); #1;
    chk("scoreboard_drained", 16'(sb_q.size()), 16'd0);
    mism = 0;
    for (int i = 0; i < 256; i++) if (spm[i] !== ref_mem[i]) mism++;
    chk("mem_contents", 16'(mism), 16'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
